// File: rtl/lsu_mem_ctrl_pkg.sv
// LSU shared types: FSM states, funct3 size codes, defaults.
// Request legality helper used at accept time.
package lsu_mem_ctrl_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes only exist for loads.
  function automatic logic req_bad(
    input logic [2:0] size,
    input logic       we,
    input logic [1:0] a
  );
    logic bad;
    bad = 1'b0;
    case (size)
      F3_B:    bad = 1'b0;
      F3_H:    bad = a[0];
      F3_W:    bad = |a;
      F3_BU:   bad = we;
      F3_HU:   bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Word bus between the LSU and memory.
// Valid/ready request channel, single-beat response.
interface lsu_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            bus_req_valid;
  logic            bus_req_ready;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_wstrb;
  logic            bus_rsp_valid;
  logic [XLEN-1:0] bus_rsp_rdata;
  logic            bus_rsp_err;

  modport master (
    output bus_req_valid, bus_we, bus_addr,
    output bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid,
    input  bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr,
    input  bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid,
    output bus_rsp_rdata, bus_rsp_err
  );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane steering: store strobes/replication and
// load byte/half extraction with sign or zero extension.
module lsu_mem_ctrl_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      a,
  input  logic [2:0]      size,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wlane,
  output logic [XLEN-1:0] rfmt
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = rdata[{a, 3'b000} +: 8];
    h     = rdata[{a[1], 4'b0000} +: 16];
    wstrb = 4'b1111;
    wlane = wdata;
    rfmt  = rdata;
    case (size[1:0])
      2'b00: begin
        wstrb = 4'b0001 << a;
        wlane = {(XLEN/8){wdata[7:0]}};
        rfmt  = size[2] ? {{(XLEN-8){1'b0}}, b}
                        : {{(XLEN-8){b[7]}}, b};
      end
      2'b01: begin
        wstrb = 4'b0011 << a;
        wlane = {(XLEN/16){wdata[15:0]}};
        rfmt  = size[2] ? {{(XLEN-16){1'b0}}, h}
                        : {{(XLEN-16){h[15]}}, h};
      end
      default: begin
        wstrb = 4'b1111;
        wlane = wdata;
        rfmt  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one EXU request, runs it on the
// word bus, formats load data and stalls the core meanwhile.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_r_en,
  input  logic            mem_w_en,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_w,
  input  logic [2:0]      mem_size,
  output logic [XLEN-1:0] mem_r,
  output logic            lsu_busy,
  output logic            lsu_done,
  output logic            lsu_err,
  lsu_mem_ctrl_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  lsu_state_t      state, state_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [2:0]      size_q;
  logic            we_q, err_q, err_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            accept, load_ok, bad;
  logic [3:0]      strb;
  logic [XLEN-1:0] wlane, rfmt;

  assign bad = (mem_r_en & mem_w_en) |
               req_bad(mem_size, mem_w_en, mem_addr[1:0]);

  always_comb begin
    state_d = state;
    err_d   = err_q;
    cnt_d   = cnt;
    accept  = 1'b0;
    load_ok = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_r_en | mem_w_en) begin
          accept  = ~bad;
          err_d   = bad;
          state_d = bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.bus_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (bus.bus_rsp_valid) begin
          state_d = S_DONE;
          err_d   = bus.bus_rsp_err;
          load_ok = ~we_q & ~bus.bus_rsp_err;
        end else begin
          cnt_d = cnt + 1'b1;
          if (cnt_d == TMO) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      mem_r   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_w;
        size_q  <= mem_size;
        we_q    <= mem_w_en;
      end
      err_q <= err_d;
      cnt   <= cnt_d;
      if (load_ok) mem_r <= rfmt;
    end
  end

  lsu_mem_ctrl_align #(.XLEN(XLEN)) u_align (
    .a     (addr_q[1:0]),
    .size  (size_q),
    .wdata (wdata_q),
    .rdata (bus.bus_rsp_rdata),
    .wstrb (strb),
    .wlane (wlane),
    .rfmt  (rfmt)
  );

  assign bus.bus_req_valid = (state == S_REQ);
  assign bus.bus_we        = we_q;
  assign bus.bus_addr      = {addr_q[XLEN-1:2], 2'b00};
  assign bus.bus_wdata     = wlane;
  assign bus.bus_wstrb     = we_q ? strb : 4'b0000;

  // Combinational in the accept cycle so the PC holds there too.
  assign lsu_busy = (state == S_REQ) || (state == S_WAIT) ||
                    ((state == S_IDLE) && (mem_r_en || mem_w_en));
  assign lsu_done = (state == S_DONE);
  assign lsu_err  = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a
// transaction-level reference model.
module tb_lsu_mem_ctrl;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_addr, mem_w, mem_r;
  logic [2:0]  mem_size;
  logic        lsu_busy, lsu_done, lsu_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_mr = 32'h0;

  lsu_mem_ctrl_if #(.XLEN(32)) bus ();

  lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .mem_addr (mem_addr),
    .mem_w    (mem_w),
    .mem_size (mem_size),
    .mem_r    (mem_r),
    .lsu_busy (lsu_busy),
    .lsu_done (lsu_done),
    .lsu_err  (lsu_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction: model the outcome, then play the bus side.
  // rsp_dly < 0 means the bus never answers.
  task automatic run_op(input bit is_w, input bit both,
                        input logic [2:0] sz,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] rd,
                        input bit rerr,
                        input int rdy_dly,
                        input int rsp_dly,
                        input bit early);
    int      n, done_at, hs, lim;
    bit      bad, eerr, ok, seen;
    logic [3:0]  es;
    logic [31:0] ew, ea;
    longint  v, mask;

    n   = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    bad = both || sz == 3'd3 || sz >= 3'd6 || (is_w && sz[2]) ||
          ((a % n) != 0);
    ea  = a - (a % 4);
    es  = is_w ? 4'(((1 << n) - 1) << (a % 4)) : 4'b0000;
    for (int i = 0; i < 4; i++) ew[8*i +: 8] = wd[8*(i % n) +: 8];
    mask = (longint'(1) << (8 * n)) - 1;
    v    = (longint'(rd) >> (8 * (a % 4))) & mask;
    if (!sz[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));

    if (bad) begin
      eerr = 1'b1; done_at = 1;
    end else if (rsp_dly < 0) begin
      eerr = 1'b1; done_at = rdy_dly + TMO + 2;
    end else begin
      eerr = rerr; done_at = rdy_dly + rsp_dly + 3;
    end
    if (!bad && !is_w && !eerr) model_mr = 32'(v);

    @(negedge clk);
    mem_r_en = !is_w || both;
    mem_w_en = is_w || both;
    mem_addr = a;
    mem_w    = wd;
    mem_size = sz;
    #1 chk("busy_accept", 32'(lsu_busy), 32'd1);

    hs = -1; ok = 1'b1; seen = 1'b0; lim = done_at + 3;
    for (int f = 1; f <= lim && !seen; f++) begin
      @(negedge clk);
      if (f == 1) begin
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        mem_addr = $urandom; mem_w = $urandom;
        mem_size = 3'($urandom);
      end
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rsp_err   = 1'b0;
      #1;
      if (lsu_done) begin
        seen = 1'b1;
        chk("done_latency", 32'(f), 32'(done_at));
        chk("err", 32'(lsu_err), 32'(eerr));
        chk("mem_r", mem_r, model_mr);
        if (lsu_busy || bus.bus_req_valid) ok = 1'b0;
      end else begin
        if (!lsu_busy) ok = 1'b0;
        if (bus.bus_req_valid) begin
          if (bad || bus.bus_addr !== ea || bus.bus_we !== is_w ||
              bus.bus_wstrb !== es || (is_w && bus.bus_wdata !== ew))
            ok = 1'b0;
          if (f - 1 == rdy_dly) begin
            hs = f;
            bus.bus_req_ready = 1'b1;
            chk("bus_addr", bus.bus_addr, ea);
            chk("bus_we", 32'(bus.bus_we), 32'(is_w));
            chk("bus_wstrb", 32'(bus.bus_wstrb), 32'(es));
            if (is_w) chk("bus_wdata", bus.bus_wdata, ew);
            if (early) begin
              bus.bus_rsp_valid = 1'b1;
              bus.bus_rsp_rdata = $urandom;
              bus.bus_rsp_err   = 1'b1;
            end
          end
        end else if (hs > 0 && rsp_dly >= 0 && f == hs + 1 + rsp_dly) begin
          bus.bus_rsp_valid = 1'b1;
          bus.bus_rsp_rdata = rd;
          bus.bus_rsp_err   = rerr;
        end
      end
    end
    if (!seen) chk("done_seen", 32'd0, 32'd1);
    chk("req_stable_busy", 32'(ok), 32'd1);
    @(negedge clk);
    bus.bus_rsp_valid = 1'b0;
    bus.bus_req_ready = 1'b0;
    #1 chk("done_pulse", {30'd0, lsu_done, lsu_busy}, 32'd0);
  endtask

  initial begin
    int n;
    bit w, bth, re, er;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [2:0]  szs [6];
    szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

    rst_n = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    mem_addr = '0; mem_w = '0; mem_size = '0;
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_rdata = '0;
    bus.bus_rsp_err   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_r", mem_r, 32'd0);
    chk("rst_ctl", {28'd0, lsu_busy, lsu_done, lsu_err,
                    bus.bus_req_valid}, 32'd0);
    chk("rst_bus", {bus.bus_addr[27:0], bus.bus_wstrb},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1, 0, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    run_op(0, 0, 3'd0, 32'h8000_0003, 0, 32'h80FF_0000, 0, 0, 0, 0);
    chk("lb_value", model_mr, 32'hFFFF_FF80);
    run_op(0, 0, 3'd4, 32'h8000_0003, 0, 32'h80FF_0000, 0, 0, 0, 0);
    chk("lbu_value", model_mr, 32'h0000_0080);
    run_op(1, 0, 3'd1, 32'h8000_0002, 32'h0000_1234, 0, 0, 0, 0, 0);
    run_op(0, 0, 3'd2, 32'h8000_0002, 0, 32'h1111_2222, 0, 0, 0, 0);
    run_op(0, 0, 3'd1, 32'h8000_0002, 0, 32'h8765_4321, 0, 5, 2, 1);
    run_op(1, 0, 3'd2, 32'h8000_0010, 32'h5555_AAAA, 0, 0, 1, -1, 0);
    run_op(0, 1, 3'd2, 32'h8000_0000, 32'h1, 32'h2, 0, 0, 0, 0);
    run_op(0, 0, 3'd2, 32'h8000_0008, 0, 32'hCAFE_F00D, 1, 0, 1, 0);

    for (int k = 0; k < 60; k++) begin
      w   = 1'($urandom);
      bth = ($urandom % 25) == 0;
      sz  = szs[($urandom % 12 == 0) ? 5 : $urandom % 5];
      n   = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
      a   = $urandom;
      if ($urandom % 6 != 0) a = a - (a % n);
      re  = ($urandom % 8) == 0;
      er  = 1'($urandom);
      run_op(w, bth, sz, a, $urandom, $urandom, re,
             int'($urandom % 4), int'($urandom % 4), er);
    end

    // Reset while waiting for a load response.
    @(negedge clk);
    mem_r_en = 1'b1; mem_addr = 32'h8000_0020; mem_size = 3'd2;
    @(negedge clk);
    mem_r_en = 1'b0;
    bus.bus_req_ready = 1'b1;
    @(negedge clk);
    bus.bus_req_ready = 1'b0;
    #1 chk("pre_rst_busy", 32'(lsu_busy), 32'd1);
    rst_n = 1'b0;
    model_mr = 32'h0;
    #1;
    chk("midrst_ctl", {29'd0, lsu_busy, lsu_done,
                       bus.bus_req_valid}, 32'd0);
    chk("midrst_mem_r", mem_r, model_mr);
    @(negedge clk);
    rst_n = 1'b1;
    bus.bus_rsp_valid = 1'b1;
    bus.bus_rsp_rdata = 32'h1234_5678;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      bus.bus_rsp_valid = 1'b0;
      #1 chk("late_rsp", {31'd0, lsu_done} | mem_r, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
